fc_frame_stack: RTL

- Call-frame save/restore stack that sits directly downstream of the register management system's `fcOut` bus and feeds its `fcIn` and `restore` inputs.
- On a call it captures the 240-bit saved-register frame (15 x 16-bit) and serialises it, one word per cycle, into a word-wide stack RAM.
- On a return it reads the most recent frame back, reassembles it, and pulses `restore` so the register file reloads it.

---
 rtl/fc_frame_stack.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fc_frame_stack.sv
`default_nettype none
// fc_frame_stack: LIFO call-frame stack, serialising NWORDS x 16-bit frames through a word RAM.
// Optional high-water-mark counter enabled by macro FC_FRAME_STACK_HWM_EN. Rev 1.0
module fc_frame_stack #(
  parameter int DEPTH  = 8,
  parameter int NWORDS = 15,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  call,
  input  logic                  ret,
  input  logic [16*NWORDS-1:0]  fcOut_in,
  output logic [16*NWORDS-1:0]  fcIn_out,
  output logic                  restore,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  underflow,
  output logic [DW-1:0]         depth,
  output logic [DW-1:0]         hwm
);
  localparam int FW = 16 * NWORDS;
  localparam int AW = $clog2(DEPTH * NWORDS);
  localparam int KW = $clog2(NWORDS);
  localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PUSH    = 2'd1;
  localparam logic [1:0] S_POP_RD  = 2'd2;
  localparam logic [1:0] S_POP_FIN = 2'd3;

  logic [1:0]    r_state;
  logic [KW-1:0] r_k;
  logic [DW-1:0] r_depth;
  logic [FW-1:0] r_shift;
  logic [FW-1:0] r_asm;
  logic [FW-1:0] r_fcin;
  logic          r_restore, r_done, r_ovf, r_unf;
  logic [15:0]   r_mem [DEPTH*NWORDS];
  logic [15:0]   r_rdata;

  logic [DW-1:0] w_frame;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_depth_inc;
  logic          w_push_last;

  // A push targets the next free frame; a pop reads the top occupied one.
  assign w_frame     = (r_state == S_PUSH) ? r_depth : r_depth - DW'(1);
  assign w_addr      = AW'(w_frame) * AW'(NWORDS) + AW'(r_k);
  assign w_depth_inc = r_depth + DW'(1);
  assign w_push_last = (r_state == S_PUSH) && (r_k == K_LAST);

  always_ff @(posedge clk) begin
    if (r_state == S_PUSH)
      r_mem[w_addr] <= r_shift[15:0];
    if (r_state == S_POP_RD)
      r_rdata <= r_mem[w_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_depth   <= '0;
      r_shift   <= '0;
      r_asm     <= '0;
      r_fcin    <= '0;
      r_restore <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      r_restore <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (call) begin
            if (r_depth != DW'(DEPTH)) begin
              r_shift <= fcOut_in;
              r_k     <= '0;
              r_state <= S_PUSH;
            end else begin
              r_ovf <= 1'b1;
            end
          end else if (ret) begin
            if (r_depth != '0) begin
              r_k     <= '0;
              r_state <= S_POP_RD;
            end else begin
              r_unf <= 1'b1;
            end
          end
        end
        S_PUSH: begin
          r_shift <= {16'h0000, r_shift[FW-1:16]};
          r_k     <= r_k + KW'(1);
          if (w_push_last) begin
            r_depth <= w_depth_inc;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_POP_RD: begin
          r_k <= r_k + KW'(1);
          // Read data lags the address by one cycle, so slot k-1 fills while k is issued.
          if (r_k != '0)
            r_asm <= {r_rdata, r_asm[FW-1:16]};
          if (r_k == K_LAST)
            r_state <= S_POP_FIN;
        end
        S_POP_FIN: begin
          r_fcin    <= {r_rdata, r_asm[FW-1:16]};
          r_depth   <= r_depth - DW'(1);
          r_restore <= 1'b1;
          r_done    <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FC_FRAME_STACK_HWM_EN
  logic [DW-1:0] r_hwm;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_hwm <= '0;
    else if (w_push_last && (w_depth_inc > r_hwm))
      r_hwm <= w_depth_inc;
  end
  assign hwm = r_hwm;
`else
  assign hwm = '0;
`endif

  assign fcIn_out  = r_fcin;
  assign restore   = r_restore;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign depth     = r_depth;

endmodule
`default_nettype wire
